// File: rtl/conv_pkg.sv
// Shared types and constants for the Sobel window controller.
// The kernel-select encoding matches what the convolution datapath expects.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ACTIVE    = 2'd1,
      WAIT_FEND = 2'd2
   } ctrl_state_t;

   localparam int DEF_IMG_WIDTH  = 640;
   localparam int DEF_IMG_HEIGHT = 480;

   localparam logic KERNEL_VERT = 1'b1;
   localparam logic KERNEL_HOR  = 1'b0;

endpackage

// File: rtl/conv_pos_counter.sv
// Raster position counter: column wraps into the next row, and o_last flags
// the final pixel of the frame so the controller can close it out.
module conv_pos_counter
   import conv_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int COL_W      = $clog2(IMG_WIDTH),
   parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clear,
   input  logic             i_advance,
   output logic [COL_W-1:0] o_col,
   output logic [ROW_W-1:0] o_row,
   output logic             o_last
);

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic             w_col_wrap;

   assign w_col_wrap = (r_col == LAST_COL);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_advance) begin
         if (w_col_wrap) begin
            r_col <= '0;
            r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_col  = r_col;
   assign o_row  = r_row;
   assign o_last = w_col_wrap && (r_row == LAST_ROW);

endmodule

// File: rtl/conv_window_ctrl.sv
// Frame sequencing for the 3x3 Sobel datapath: tracks pixel position, flags
// interior windows and reports frame completion / framing errors, all 1 cycle late.
module conv_window_ctrl
   import conv_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int COL_W      = $clog2(IMG_WIDTH),
   parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iFVAL,
   input  logic             iDVAL,
   input  logic             iMODE_REQ,
   output logic             oVERTICAL,
   output logic             oWIN_VALID,
   output logic [COL_W-1:0] oCOL,
   output logic [ROW_W-1:0] oROW,
   output logic             oFRAME_DONE,
   output logic             oFRAME_ERR
);

   ctrl_state_t      r_state;
   logic             r_fval_d;
   logic             r_vertical;
   logic             r_win_valid;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic             r_done;
   logic             r_err;

   logic [COL_W-1:0] w_col;
   logic [ROW_W-1:0] w_row;
   logic             w_last;
   logic             w_fval_rise;
   logic             w_start;
   logic             w_accept;

   assign w_fval_rise = iFVAL && !r_fval_d;
   assign w_start     = (r_state == IDLE) && w_fval_rise;
   // The final pixel is still taken when iFVAL drops with it; any other pixel
   // arriving with iFVAL low is treated as a short frame instead.
   assign w_accept    = (r_state == ACTIVE) && iDVAL && (iFVAL || w_last);

   conv_pos_counter #(
      .IMG_WIDTH (IMG_WIDTH),
      .IMG_HEIGHT(IMG_HEIGHT),
      .COL_W     (COL_W),
      .ROW_W     (ROW_W)
   ) u_pos (
      .i_clk    (iCLK),
      .i_rst    (iRST),
      .i_clear  (w_start),
      .i_advance(w_accept),
      .o_col    (w_col),
      .o_row    (w_row),
      .o_last   (w_last)
   );

   // Edge register resets high so a frame already running at reset release is skipped.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_state     <= IDLE;
         r_fval_d    <= 1'b1;
         r_vertical  <= KERNEL_HOR;
         r_win_valid <= 1'b0;
         r_col       <= '0;
         r_row       <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_fval_d    <= iFVAL;
         r_win_valid <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_vertical <= iMODE_REQ ? KERNEL_VERT : KERNEL_HOR;
                  r_state    <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (w_accept) begin
                  r_col       <= w_col;
                  r_row       <= w_row;
                  r_win_valid <= (w_col >= COL_W'(2)) && (w_row >= ROW_W'(2));
                  if (w_last) begin
                     r_done  <= 1'b1;
                     r_state <= iFVAL ? WAIT_FEND : IDLE;
                  end
               end else if (!iFVAL) begin
                  r_err   <= 1'b1;
                  r_state <= IDLE;
               end
            end
            WAIT_FEND: begin
               if (iDVAL) begin
                  r_err <= 1'b1;
               end
               if (!iFVAL) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign oVERTICAL   = r_vertical;
   assign oWIN_VALID  = r_win_valid;
   assign oCOL        = r_col;
   assign oROW        = r_row;
   assign oFRAME_DONE = r_done;
   assign oFRAME_ERR  = r_err;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Randomised and directed bench for conv_window_ctrl on an 8x6 image, checked
// cycle by cycle against a raster-index reference model.
module tb_conv_window_ctrl;

   localparam int W     = 8;
   localparam int H     = 6;
   localparam int COL_W = $clog2(W);
   localparam int ROW_W = $clog2(H);

   logic             iCLK;
   logic             iRST;
   logic             iFVAL;
   logic             iDVAL;
   logic             iMODE_REQ;
   logic             oVERTICAL;
   logic             oWIN_VALID;
   logic [COL_W-1:0] oCOL;
   logic [ROW_W-1:0] oROW;
   logic             oFRAME_DONE;
   logic             oFRAME_ERR;

   int checks = 0;
   int errors = 0;

   // Reference model: frame position is a single raster index
   bit mPrevF    = 1'b1;
   bit mInFrame  = 1'b0;
   bit mWaitEnd  = 1'b0;
   int mIdx      = 0;
   int mVert     = 0;
   int mCol      = 0;
   int mRow      = 0;
   int mWin      = 0;
   int mDone     = 0;
   int mErr      = 0;

   int winCount  = 0;
   int doneCount = 0;
   int errCount  = 0;

   conv_window_ctrl #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H)
   ) dut (
      .iCLK       (iCLK),
      .iRST       (iRST),
      .iFVAL      (iFVAL),
      .iDVAL      (iDVAL),
      .iMODE_REQ  (iMODE_REQ),
      .oVERTICAL  (oVERTICAL),
      .oWIN_VALID (oWIN_VALID),
      .oCOL       (oCOL),
      .oROW       (oROW),
      .oFRAME_DONE(oFRAME_DONE),
      .oFRAME_ERR (oFRAME_ERR)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelStep(input bit rst, input bit f, input bit d, input bit m);
      bit last;
      if (rst) begin
         mPrevF = 1'b1; mInFrame = 1'b0; mWaitEnd = 1'b0; mIdx = 0; mVert = 0;
         mCol = 0; mRow = 0; mWin = 0; mDone = 0; mErr = 0;
         return;
      end
      mWin = 0; mDone = 0; mErr = 0;
      if (mInFrame) begin
         last = (mIdx == W * H - 1);
         if (d && (f || last)) begin
            mCol = mIdx % W;
            mRow = mIdx / W;
            mWin = (mCol >= 2 && mRow >= 2) ? 1 : 0;
            if (last) begin
               mDone    = 1;
               mInFrame = 1'b0;
               mWaitEnd = f;
            end else begin
               mIdx++;
            end
         end else if (!f) begin
            mErr     = 1;
            mInFrame = 1'b0;
         end
      end else if (mWaitEnd) begin
         if (d) mErr = 1;
         if (!f) mWaitEnd = 1'b0;
      end else if (f && !mPrevF) begin
         mInFrame = 1'b1;
         mIdx     = 0;
         mVert    = m ? 1 : 0;
      end
      mPrevF = f;
   endtask

   task automatic applyStimulus(input bit rst, input bit f, input bit d, input bit m);
      iRST = rst; iFVAL = f; iDVAL = d; iMODE_REQ = m;
      @(posedge iCLK);
      modelStep(rst, f, d, m);
      #1;
      checkOutput("vertical",  int'(oVERTICAL),   mVert);
      checkOutput("winValid",  int'(oWIN_VALID),  mWin);
      checkOutput("col",       int'(oCOL),        mCol);
      checkOutput("row",       int'(oROW),        mRow);
      checkOutput("frameDone", int'(oFRAME_DONE), mDone);
      checkOutput("frameErr",  int'(oFRAME_ERR),  mErr);
      winCount  += int'(oWIN_VALID);
      doneCount += int'(oFRAME_DONE);
      errCount  += int'(oFRAME_ERR);
   endtask

   task automatic clearCounts();
      winCount = 0; doneCount = 0; errCount = 0;
   endtask

   // Frame start (iFVAL low then high) followed by nPix accepted pixels
   task automatic sendFrame(input int nPix, input bit toggle, input bit modeA,
                            input int switchAt, input bit modeB);
      bit m;
      applyStimulus(0, 0, 0, modeA);
      applyStimulus(0, 1, 0, modeA);
      for (int i = 0; i < nPix; i++) begin
         m = (i >= switchAt) ? modeB : modeA;
         if (toggle) applyStimulus(0, 1, 0, m);
         applyStimulus(0, 1, 1, m);
      end
   endtask

   task automatic endFrame(input bit m);
      applyStimulus(0, 1, 0, m);
      applyStimulus(0, 0, 0, m);
   endtask

   initial begin
      bit f;
      bit d;
      iRST = 1'b1; iFVAL = 1'b0; iDVAL = 1'b0; iMODE_REQ = 1'b0;

      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 1, 1, 1);

      // Full frame, continuous pixels, vertical kernel
      clearCounts();
      sendFrame(W * H, 1'b0, 1'b1, W * H, 1'b1);
      endFrame(1'b1);
      checkOutput("fullWinCount", winCount, 24);
      checkOutput("fullDoneCount", doneCount, 1);
      checkOutput("fullErrCount", errCount, 0);

      // Same frame with iDVAL toggling
      clearCounts();
      sendFrame(W * H, 1'b1, 1'b1, W * H, 1'b1);
      endFrame(1'b1);
      checkOutput("toggleWinCount", winCount, 24);
      checkOutput("toggleDoneCount", doneCount, 1);

      // Mode request changes mid-frame, then takes effect next frame
      sendFrame(W * H, 1'b0, 1'b0, 20, 1'b1);
      endFrame(1'b1);
      checkOutput("midFrameVertical", int'(oVERTICAL), 0);
      sendFrame(0, 1'b0, 1'b1, 0, 1'b1);
      checkOutput("nextFrameVertical", int'(oVERTICAL), 1);
      for (int i = 0; i < W * H; i++) applyStimulus(0, 1, 1, 1);
      endFrame(1'b1);

      // Short frame then a normal one
      clearCounts();
      sendFrame(30, 1'b0, 1'b0, 30, 1'b0);
      applyStimulus(0, 0, 1, 0);
      checkOutput("shortErrCount", errCount, 1);
      checkOutput("shortDoneCount", doneCount, 0);
      clearCounts();
      sendFrame(W * H, 1'b0, 1'b0, W * H, 1'b0);
      endFrame(1'b0);
      checkOutput("recoverDoneCount", doneCount, 1);
      checkOutput("recoverErrCount", errCount, 0);

      // Overrun after the last pixel
      clearCounts();
      sendFrame(W * H, 1'b0, 1'b1, W * H, 1'b1);
      applyStimulus(0, 1, 1, 1);
      applyStimulus(0, 1, 1, 1);
      checkOutput("overrunErrCount", errCount, 2);
      checkOutput("overrunCol", int'(oCOL), W - 1);
      checkOutput("overrunRow", int'(oROW), H - 1);
      applyStimulus(0, 0, 0, 1);

      // Last pixel arrives with iFVAL already falling
      clearCounts();
      sendFrame(W * H - 1, 1'b0, 1'b0, W * H, 1'b0);
      applyStimulus(0, 0, 1, 0);
      checkOutput("fallLastDone", int'(oFRAME_DONE), 1);
      applyStimulus(0, 0, 0, 0);
      checkOutput("fallLastErrCount", errCount, 0);

      // Reset mid-frame with iFVAL held high
      clearCounts();
      sendFrame(17, 1'b0, 1'b1, 17, 1'b1);
      applyStimulus(1, 1, 1, 1);
      for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, 1);
      checkOutput("postResetWinCount", winCount, 0);
      checkOutput("postResetRow", int'(oROW), 0);
      sendFrame(1, 1'b0, 1'b1, 1, 1'b1);
      checkOutput("restartCol", int'(oCOL), 0);
      for (int i = 1; i < W * H; i++) applyStimulus(0, 1, 1, 1);
      endFrame(1'b1);

      // Randomised traffic
      f = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 79) == 0) f = ~f;
         d = ($urandom_range(0, 3) != 0);
         applyStimulus($urandom_range(0, 699) == 0, f, d, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Sequencing controller for the 3x3 Sobel convolution datapath and its two-row line buffer.
- Tracks pixel position within a frame and flags when the 3x3 window is fully inside the image.
- Latches the vertical/horizontal kernel select only at frame boundaries, and reports frame completion and framing errors.
- Sits between the sensor-side pixel stream (iFVAL/iDVAL) and the convolution output register stage.

Parameters:
- IMG_WIDTH, 640, pixels per line (>= 3)
- IMG_HEIGHT, 480, lines per frame (>= 3)
- COL_W, $clog2(IMG_WIDTH), column counter width
- ROW_W, $clog2(IMG_HEIGHT), row counter width

Ports:
- iCLK  in  1  pixel clock
- iRST  in  1  synchronous, active-high reset
- iFVAL  in  1  frame valid from the capture stage
- iDVAL  in  1  pixel valid; one pixel accepted per cycle when high and the block is in ACTIVE
- iMODE_REQ  in  1  requested kernel: 1 = vertical, 0 = horizontal
- oVERTICAL  out  1  kernel select driven to the convolution datapath; stable for a whole frame
- oWIN_VALID  out  1  registered; convolution result for the previous accepted pixel is a valid interior window
- oCOL  out  COL_W  column of the last accepted pixel (registered)
- oROW  out  ROW_W  row of the last accepted pixel (registered)
- oFRAME_DONE  out  1  one-cycle pulse when the last pixel of the frame is accepted
- oFRAME_ERR  out  1  one-cycle pulse on a short frame or overrun

Behaviour:
- Clock and reset: one clock, iCLK. iRST is synchronous and active-high.
- Reset values: oVERTICAL=0, oWIN_VALID=0, oCOL=0, oROW=0, oFRAME_DONE=0, oFRAME_ERR=0, state=IDLE, iFVAL edge register=1 (so a frame already in progress at reset release is never entered mid-way).
- IDLE:
  - iDVAL is ignored.
  - On an iFVAL rising edge (registered previous value 0, current 1): clear the counters, latch oVERTICAL<=iMODE_REQ, go to ACTIVE.
- ACTIVE, on each cycle with iDVAL=1 (accept):
  - Update oCOL/oROW to the current position, then advance the position.
  - col wraps IMG_WIDTH-1 -> 0 and increments row.
  - oWIN_VALID (next cycle) = 1 iff the accepted pixel has row >= 2 and col >= 2, i.e. all 9 taps come from the current frame and the current two lines (no horizontal wrap).
  - Cycles with iDVAL=0: oWIN_VALID=0; counters and outputs hold.
- Frame completion: accepting the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) pulses oFRAME_DONE on the next cycle and moves to WAIT_FEND. That pixel's oWIN_VALID is 1.
- WAIT_FEND:
  - iDVAL=1 is an overrun: pulse oFRAME_ERR, pixel ignored, oWIN_VALID=0.
  - iFVAL=0 -> IDLE.
- Short frame: iFVAL falls while in ACTIVE -> pulse oFRAME_ERR, go to IDLE. No oFRAME_DONE.
- Simultaneous events:
  - iFVAL falling in the same cycle as the final accepted pixel: the pixel is accepted, oFRAME_DONE pulses, no error, and the FSM goes directly to IDLE.
  - iFVAL low with iDVAL high in ACTIVE: the short-frame rule wins and the pixel is not accepted.
- Mode changes: iMODE_REQ is sampled only on the IDLE -> ACTIVE transition. Mid-frame changes have no effect until the next frame.
- Reset mid-frame: forces IDLE. The controller must then see iFVAL low before a new frame is accepted.
- Latency: oWIN_VALID, oCOL, oROW and the pulses are all exactly 1 cycle after the accepting edge. This aligns them with a single output register on pixel_out.
- Arithmetic: counters are unsigned. No other arithmetic.

Decomposition:
- Package conv_pkg holds:
  - enum ctrl_state_t {IDLE, ACTIVE, WAIT_FEND}
  - default IMG_WIDTH/IMG_HEIGHT constants
  - the KERNEL_VERT=1 / KERNEL_HOR=0 encoding
- One natural sub-module: conv_pos_counter (col/row counter with wrap and last-pixel flag), instantiated once.

Test Plan (all scenarios use IMG_WIDTH=8, IMG_HEIGHT=6):
- Full frame, continuous iDVAL, iMODE_REQ=1 -> 48 accepts; oWIN_VALID high for exactly 24 cycles (rows 2-5, cols 2-7); oFRAME_DONE pulses once, 1 cycle after pixel (5,7); oVERTICAL=1 throughout.
- Same frame with iDVAL toggling every other cycle -> same 24 oWIN_VALID pulses and oCOL/oROW sequence; counters hold on idle cycles.
- iMODE_REQ toggled 0->1 at pixel 20 of frame 1 -> oVERTICAL stays 0 for all of frame 1; oVERTICAL=1 at the first cycle after frame 2's iFVAL rising edge.
- iFVAL dropped after 30 pixels -> oFRAME_ERR single pulse, no oFRAME_DONE, state IDLE; the next full frame completes normally.
- 2 extra iDVAL pixels after pixel (5,7) with iFVAL still high -> 2 oFRAME_ERR pulses, oWIN_VALID=0, counters unchanged.
- iRST asserted at pixel 17 with iFVAL held high -> no activity until iFVAL goes low then high; the next frame starts counting at (0,0).
